// File: rtl/round_robin_mask_ctrl.sv
// Round-robin mask and registered grant holder feeding a masked priority arbiter.
// Optional forced release after TIMEOUT hold cycles when RR_TIMEOUT_EN is defined.
module round_robin_mask_ctrl #(
  parameter int width   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] request,
  input  logic [width-1:0] arb_grant,
  input  logic             done,
  output logic [width-1:0] masked_request,
  output logic [width-1:0] mask,
  output logic [width-1:0] grant,
  output logic             grant_valid,
  output logic             timeout
);

  localparam logic IDLE = 1'b0;
  localparam logic BUSY = 1'b1;
  localparam logic [width-1:0] ONE = {{(width-1){1'b0}}, 1'b1};

  logic             state;
  logic [width-1:0] next_mask;
  logic             onehot;
  logic             accept;
  logic             release_req;
  logic             release_all;

  assign masked_request = request & mask;

  assign onehot = (arb_grant != '0) &&
                  ((arb_grant & (arb_grant - ONE)) == '0);

  assign accept = (state == IDLE) && (request != '0) && onehot &&
                  ((arb_grant & ~request) == '0);

  assign release_req = (state == BUSY) &&
                       (done || ((grant & request) == '0));

  // Bits above the owner stay enabled; owner at the top wraps to zero.
  assign next_mask = ~((grant << 1) - ONE);

`ifdef RR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;

  logic [CW-1:0] hold;
  logic          force_rel;

  assign force_rel = (state == BUSY) && !release_req &&
                     (hold == CW'(TIMEOUT - 1));
  assign timeout     = force_rel;
  assign release_all = release_req || force_rel;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold <= '0;
    end else if ((state == BUSY) && !release_all) begin
      hold <= hold + 1'b1;
    end else begin
      hold <= '0;
    end
  end
`else
  assign timeout     = 1'b0;
  assign release_all = release_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      mask        <= '1;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            grant       <= arb_grant;
            grant_valid <= 1'b1;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (release_all) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            mask        <= next_mask;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_round_robin_mask_ctrl.sv
// Scoreboard bench for round_robin_mask_ctrl with an index-based reference model.
// Timeout scenarios run when RR_TIMEOUT_EN is defined.
module tb_round_robin_mask_ctrl;

`ifdef RR_TIMEOUT_EN
  localparam int TO = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO = 16;
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] grant;
    logic       gv;
    logic [7:0] mask;
    logic [7:0] mreq;
    logic       to;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] request;
  logic [7:0] arb_grant;
  logic       done;
  logic [7:0] masked_request;
  logic [7:0] mask;
  logic [7:0] grant;
  logic       grant_valid;
  logic       timeout;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  bit         m_busy;
  int         m_owner;
  logic [7:0] m_mask;
  int         m_held;

  round_robin_mask_ctrl #(.width(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .request(request), .arb_grant(arb_grant),
    .done(done), .masked_request(masked_request), .mask(mask),
    .grant(grant), .grant_valid(grant_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++)
      if (v[i]) return 8'(1 << i);
    return 8'h00;
  endfunction

  function automatic int count_ones(input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp,
               $time);
    end
  endtask

  // Reference: owner index, mask built from "bits above the owner" rule.
  task automatic model_step(input logic r, input logic [7:0] req,
                            input logic [7:0] ag, input logic dn);
    exp_t e;
    bit rel;
    bit frc;
    if (r) begin
      m_busy = 0; m_owner = -1; m_mask = 8'hFF; m_held = 0;
    end else if (!m_busy) begin
      if (count_ones(ag) == 1 && (ag & ~req) == 8'h00) begin
        m_busy = 1; m_held = 0;
        for (int i = 0; i < 8; i++) if (ag[i]) m_owner = i;
      end
    end else begin
      rel = dn || !req[m_owner];
      frc = TO_EN && !rel && (m_held == TO - 1);
      if (rel || frc) begin
        for (int i = 0; i < 8; i++) m_mask[i] = (i > m_owner);
        m_busy = 0; m_owner = -1; m_held = 0;
      end else begin
        m_held++;
      end
    end
    e.grant = m_busy ? 8'(1 << m_owner) : 8'h00;
    e.gv    = m_busy;
    e.mask  = m_mask;
    e.mreq  = req & m_mask;
    e.to    = TO_EN && m_busy && (m_held == TO - 1) &&
              !(dn || !req[m_owner]);
    q.push_back(e);
  endtask

  // mode 0: emulate downstream masked/unmasked priority arbiter; 1: explicit
  task automatic step(input logic r, input logic [7:0] req, input logic dn,
                      input int mode, input logic [7:0] agx);
    @(negedge clk);
    rst = r; request = req; done = dn;
    #1;
    if (mode == 0)
      arb_grant = lowest(masked_request != 8'h00 ? masked_request : request);
    else
      arb_grant = agx;
    model_step(r, req, arb_grant, dn);
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("grant", grant, e.grant);
      check("grant_valid", {7'd0, grant_valid}, {7'd0, e.gv});
      check("mask", mask, e.mask);
      check("masked_request", masked_request, e.mreq);
      check("timeout", {7'd0, timeout}, {7'd0, e.to});
    end
  end

  initial begin
    logic [7:0] rq;
    rst = 1'b1; request = 8'h00; arb_grant = 8'h00; done = 1'b0;
    step(1, 8'h00, 0, 1, 8'h00);
    step(1, 8'h00, 0, 1, 8'h00);
    step(0, 8'h00, 0, 1, 8'h00);
    step(0, 8'h00, 1, 1, 8'h00);
    // rotation with request 05 and done held high
    for (int i = 0; i < 6; i++) step(0, 8'h05, 1, 0, 8'h00);
    // wrap via bit 7
    step(0, 8'h80, 0, 0, 8'h00);
    step(0, 8'h80, 1, 0, 8'h00);
    step(0, 8'hFF, 0, 1, 8'h00);
    step(0, 8'h5A, 0, 1, 8'h00);
    // request drop from owner bit 4
    step(0, 8'h10, 0, 0, 8'h00);
    step(0, 8'h10, 0, 0, 8'h00);
    step(0, 8'h00, 0, 0, 8'h00);
    // invalid grants stay idle
    step(0, 8'h03, 0, 1, 8'h03);
    step(0, 8'h03, 0, 1, 8'h04);
    step(0, 8'h00, 0, 1, 8'h01);
    // long hold: forced release with timeout, else indefinite hold
    step(0, 8'h02, 0, 1, 8'h02);
    for (int i = 0; i < 20; i++) step(0, 8'h02, 0, 1, 8'h00);
    step(0, 8'h02, 1, 1, 8'h00);
    // reset wins over a simultaneous done
    step(0, 8'h04, 0, 1, 8'h04);
    step(0, 8'h04, 0, 1, 8'h00);
    step(1, 8'h04, 1, 1, 8'h00);
    step(0, 8'h00, 0, 1, 8'h00);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rq = 8'($urandom);
      if ($urandom_range(0, 3) == 0) rq = 8'h00;
      if ($urandom_range(0, 9) < 8)
        step($urandom_range(0, 49) == 0, rq, $urandom_range(0, 9) < 3,
             0, 8'h00);
      else
        step(0, rq, $urandom_range(0, 9) < 3, 1, 8'($urandom));
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
